harvard_mem_host: RTL and testbench
===================================

Name: harvard_mem_host

Overview:
- Memory-and-control host for the mips_cpu_harvard core; it serves the other end of the CPU's instruction and data interfaces.
- Provides instruction RAM mapped at the reset vector and data RAM at address 0.
- Loads a program from a valid/ready word stream, then holds the CPU in reset for a fixed time and releases it.
- Detects halt (active falling) and address faults, and counts run cycles. Sits beside the CPU in system-level benches and top-levels.

Parameters:
IMEM_WORDS, 256, instruction RAM depth in 32-bit words (power of 2)
DMEM_WORDS, 1024, data RAM depth in 32-bit words (power of 2)
RESET_CYCLES, 2, cycles cpu_reset is held high after load completes (>=1)

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
load_valid  in  1  program word present
load_ready  out  1  host accepts program word this cycle
load_data  in  32  program word, stored in load order from IMEM_BASE
load_last  in  1  marks final program word
cpu_reset  out  1  drives CPU reset
clk_enable  out  1  drives CPU clk_enable
active  in  1  CPU active flag
instr_address  in  32  CPU fetch address
instr_readdata  out  32  combinational instruction word
data_address  in  32  CPU data address
data_write  in  1  single-cycle write strobe
data_read  in  1  combinational read strobe
data_writedata  in  32  write data
data_readdata  out  32  combinational read data
done  out  1  CPU halted cleanly
fault  out  1  illegal access detected
cycle_count  out  32  rising edges spent in RUN, saturating at 32'hFFFFFFFF

Behaviour:
- States: LOAD, HOLD, RUN, HALTED, FAULT.
- Reset outputs: state=LOAD; load_ready=1; cpu_reset=1; clk_enable=0; done=0; fault=0; cycle_count=0. Word and hold counters are 0.
- Reset does not clear RAM contents.
- LOAD: load_ready=1.
  - On valid&&ready, write imem[word_cnt]=load_data and increment word_cnt.
  - Go to HOLD after accepting a word with load_last=1, or after accepting word IMEM_WORDS-1 (truncation; no fault).
  - load_valid=0 -> stall indefinitely.
- HOLD: load_ready=0, cpu_reset=1, clk_enable=1. Lasts exactly RESET_CYCLES cycles, then RUN.
- RUN: cpu_reset=0, clk_enable=1. cycle_count increments every cycle.
- Halt: active observed high at least once in RUN, then sampled 0 -> HALTED the next edge.
- Fault conditions, checked in RUN, go to FAULT the next edge (fault wins over halt when both occur in the same cycle):
  - instr_address outside [IMEM_BASE, IMEM_BASE+4*IMEM_WORDS) or bits[1:0]!=0.
  - data_read or data_write with data_address outside [0, 4*DMEM_WORDS) or bits[1:0]!=0.
  - data_read && data_write together.
- HALTED: done=1, clk_enable=0, cpu_reset=0; cycle_count frozen.
- FAULT: fault=1, clk_enable=0; cycle_count frozen.
- HALTED and FAULT exit only via reset.
- Reads are combinational in every state: instr_readdata=imem[(instr_address-IMEM_BASE)>>2]; data_readdata=dmem[data_address>>2] when data_read.
  - Out-of-range or misaligned read returns 32'h0.
  - data_read=0 -> data_readdata=0.
- Writes: dmem[data_address>>2]=data_writedata at the rising edge when data_write && state==RUN && address legal. Visible to a combinational read in the next cycle.
- Writes in any other state are ignored.
- reset mid-RUN: return to LOAD next edge with cpu_reset=1 and clk_enable=0 immediately; the next load overwrites imem from index 0.

Decomposition:
- Package mips_mem_pkg holds:
  - IMEM_BASE=32'hBFC00000, DMEM_BASE=32'h00000000.
  - host_state_t enum {LOAD,HOLD,RUN,HALTED,FAULT}.
  - Function in_window(addr, base, words) returning the range+alignment check.
- Sub-module word_ram (parameter WORDS): combinational read, synchronous single-port write. Instantiated once for imem (write port driven by loader) and once for dmem (write port driven by CPU).

Test Plan:
- Stream 3 words {32'h24010020, 32'h24030020, 32'h14600080} with load_last on the third -> load_ready drops the next cycle; cpu_reset stays high exactly 2 cycles, then falls. With instr_address=32'hBFC00008, instr_readdata=32'h14600080.
- In RUN, data_write at 32'h10 with 32'hDEADBEEF, then data_read at 32'h10 next cycle -> 32'hDEADBEEF. Reading 32'h14 -> 32'h0.
- In RUN, instr_address=32'h00000004 -> fault=1 and clk_enable=0 next edge; a later data_write at 32'h10 leaves 32'hDEADBEEF unchanged.
- Hold active=1 for 10 RUN cycles, then active=0 -> done=1 next edge; cycle_count stops at 11.
- Assert data_read and data_write in the same cycle at a legal address -> fault=1; done stays 0.
- Pulse reset during RUN -> cpu_reset=1 and load_ready=1 after the edge; cycle_count=0. Reloading 1 word 32'h00000000 with last -> instr_readdata at IMEM_BASE = 0, while index 1 still returns 32'h24030020.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types, address map and window check for the harvard memory host.
package mips_mem_pkg;

  localparam logic [31:0] IMEM_BASE = 32'hBFC00000;
  localparam logic [31:0] DMEM_BASE = 32'h00000000;

  typedef enum logic [2:0] {
    StLoad,
    StHold,
    StRun,
    StHalted,
    StFault
  } host_state_t;

  // True when addr is word-aligned and inside [base, base + 4*words).
  function automatic logic in_window(logic [31:0] addr, logic [31:0] base, int unsigned words);
    logic [32:0] off;
    logic [32:0] lim;
    off = {1'b0, addr} - {1'b0, base};
    lim = 33'(words) << 2;
    return (addr >= base) && (off < lim) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/word_ram.sv
// 32-bit word RAM: combinational read, synchronous single-port write.
module word_ram #(
  parameter int unsigned WORDS = 256,
  localparam int unsigned AW   = $clog2(WORDS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/harvard_mem_host.sv
// Memory and control host for the harvard MIPS core: program loader, reset sequencer,
// instruction/data RAMs, halt and fault detection, run-cycle counter.
module harvard_mem_host
  import mips_mem_pkg::*;
#(
  parameter int unsigned IMEM_WORDS   = 256,
  parameter int unsigned DMEM_WORDS   = 1024,
  parameter int unsigned RESET_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        cpu_reset,
  output logic        clk_enable,
  input  logic        active,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic [31:0] data_address,
  input  logic        data_write,
  input  logic        data_read,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  output logic        done,
  output logic        fault,
  output logic [31:0] cycle_count
);

  localparam int unsigned IAW = $clog2(IMEM_WORDS);
  localparam int unsigned DAW = $clog2(DMEM_WORDS);

  host_state_t    state_q, state_d;
  logic [IAW-1:0] word_cnt_q, word_cnt_d;
  logic [31:0]    hold_cnt_q, hold_cnt_d;
  logic           seen_active_q, seen_active_d;
  logic [31:0]    cycle_q, cycle_d;

  logic           i_ok, d_ok, run_fault, load_fire, dmem_we;
  logic [IAW-1:0] imem_raddr;
  logic [31:0]    imem_rdata, dmem_rdata;

  assign i_ok      = in_window(instr_address, IMEM_BASE, IMEM_WORDS);
  assign d_ok      = in_window(data_address, DMEM_BASE, DMEM_WORDS);
  assign run_fault = !i_ok || ((data_read || data_write) && !d_ok) || (data_read && data_write);
  assign load_fire = load_valid && load_ready && !reset;
  assign dmem_we   = data_write && d_ok && (state_q == StRun);

  assign imem_raddr = instr_address[IAW+1:2] - IMEM_BASE[IAW+1:2];

  word_ram #(.WORDS(IMEM_WORDS)) u_imem (
    .clk_i   (clk),
    .we_i    (load_fire),
    .waddr_i (word_cnt_q),
    .wdata_i (load_data),
    .raddr_i (imem_raddr),
    .rdata_o (imem_rdata)
  );

  word_ram #(.WORDS(DMEM_WORDS)) u_dmem (
    .clk_i   (clk),
    .we_i    (dmem_we),
    .waddr_i (data_address[DAW+1:2]),
    .wdata_i (data_writedata),
    .raddr_i (data_address[DAW+1:2]),
    .rdata_o (dmem_rdata)
  );

  assign instr_readdata = i_ok ? imem_rdata : '0;
  assign data_readdata  = (data_read && d_ok) ? dmem_rdata : '0;

  always_comb begin
    state_d       = state_q;
    word_cnt_d    = word_cnt_q;
    hold_cnt_d    = hold_cnt_q;
    seen_active_d = seen_active_q;
    cycle_d       = cycle_q;
    unique case (state_q)
      StLoad: begin
        if (load_fire) begin
          word_cnt_d = word_cnt_q + 1'b1;
          // Stream longer than imem is truncated silently.
          if (load_last || (word_cnt_q == IAW'(IMEM_WORDS - 1))) state_d = StHold;
        end
      end
      StHold: begin
        if (hold_cnt_q == 32'(RESET_CYCLES - 1)) begin
          hold_cnt_d = '0;
          state_d    = StRun;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (cycle_q != '1) cycle_d = cycle_q + 1'b1;
        if (active) seen_active_d = 1'b1;
        if (run_fault) state_d = StFault;
        else if (seen_active_q && !active) state_d = StHalted;
      end
      default: ;
    endcase
  end

  // Reset forces the CPU into reset immediately, without waiting for the edge.
  always_comb begin
    load_ready  = (state_q == StLoad);
    cpu_reset   = reset || (state_q == StLoad) || (state_q == StHold);
    clk_enable  = !reset && ((state_q == StHold) || (state_q == StRun));
    done        = (state_q == StHalted);
    fault       = (state_q == StFault);
    cycle_count = cycle_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StLoad;
      word_cnt_q    <= '0;
      hold_cnt_q    <= '0;
      seen_active_q <= 1'b0;
      cycle_q       <= '0;
    end else begin
      state_q       <= state_d;
      word_cnt_q    <= word_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      seen_active_q <= seen_active_d;
      cycle_q       <= cycle_d;
    end
  end

endmodule

// File: tb/tb_harvard_mem_host.sv
// Directed bench for harvard_mem_host: expected values queued at stimulus, popped at sampling.
module tb_harvard_mem_host;

  logic        clk = 1'b0;
  logic        reset, load_valid, load_last, active, data_write, data_read;
  logic [31:0] load_data, instr_address, data_address, data_writedata;
  logic        load_ready, cpu_reset, clk_enable, done, fault;
  logic [31:0] instr_readdata, data_readdata, cycle_count;

  harvard_mem_host dut (
    .clk            (clk),
    .reset          (reset),
    .load_valid     (load_valid),
    .load_ready     (load_ready),
    .load_data      (load_data),
    .load_last      (load_last),
    .cpu_reset      (cpu_reset),
    .clk_enable     (clk_enable),
    .active         (active),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .data_address   (data_address),
    .data_write     (data_write),
    .data_read      (data_read),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata),
    .done           (done),
    .fault          (fault),
    .cycle_count    (cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_total++;
    if (sb.size() == 0) begin
      $error("FAIL scoreboard_empty observed=%h", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.val) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic restart(input logic [31:0] w);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    load_word(w, 1'b1);
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_last = 1'b0; load_data = '0; active = 1'b0;
    data_write = 1'b0; data_read = 1'b0; data_address = '0; data_writedata = '0;
    instr_address = 32'hBFC00000;
    tick();
    tick();
    expect_v("rst_load_ready", 1);  check(32'(load_ready));
    expect_v("rst_cpu_reset", 1);   check(32'(cpu_reset));
    expect_v("rst_clk_enable", 0);  check(32'(clk_enable));
    expect_v("rst_done", 0);        check(32'(done));
    expect_v("rst_fault", 0);       check(32'(fault));
    expect_v("rst_cycles", 0);      check(cycle_count);

    // Loader stalls while no word is offered.
    reset = 1'b0;
    tick();
    tick();
    expect_v("stall_ready", 1);     check(32'(load_ready));
    expect_v("stall_cpu_reset", 1); check(32'(cpu_reset));

    load_word(32'h24010020, 1'b0);
    load_word(32'h24030020, 1'b0);
    load_word(32'h14600080, 1'b1);
    expect_v("hold_ready", 0);      check(32'(load_ready));
    expect_v("hold_cpu_reset0", 1); check(32'(cpu_reset));
    expect_v("hold_clk_en", 1);     check(32'(clk_enable));
    instr_address = 32'hBFC00008;
    #1;
    expect_v("imem_word2", 32'h14600080); check(instr_readdata);
    instr_address = 32'hBFC00000;
    tick();
    expect_v("hold_cpu_reset1", 1); check(32'(cpu_reset));
    tick();
    expect_v("run_cpu_reset", 0);   check(32'(cpu_reset));
    expect_v("run_clk_en", 1);      check(32'(clk_enable));

    // Data RAM write then combinational read.
    data_write = 1'b1; data_address = 32'h14; data_writedata = 32'h0;
    tick();
    data_address = 32'h10; data_writedata = 32'hDEADBEEF;
    tick();
    data_write = 1'b0; data_read = 1'b1;
    #1;
    expect_v("dmem_rd_10", 32'hDEADBEEF); check(data_readdata);
    data_address = 32'h14;
    #1;
    expect_v("dmem_rd_14", 32'h0);        check(data_readdata);
    data_read = 1'b0;
    expect_v("run_cycles", 2);            check(cycle_count);

    // Reset mid-RUN, then reload a single word.
    reset = 1'b1;
    #1;
    expect_v("midrst_cpu_reset_now", 1); check(32'(cpu_reset));
    expect_v("midrst_clk_en_now", 0);    check(32'(clk_enable));
    tick();
    reset = 1'b0;
    #1;
    expect_v("midrst_ready", 1);     check(32'(load_ready));
    expect_v("midrst_cpu_reset", 1); check(32'(cpu_reset));
    expect_v("midrst_cycles", 0);    check(cycle_count);
    load_word(32'h00000000, 1'b1);
    instr_address = 32'hBFC00000;
    #1;
    expect_v("reload_w0", 32'h0);      check(instr_readdata);
    instr_address = 32'hBFC00004;
    #1;
    expect_v("reload_w1", 32'h24030020); check(instr_readdata);
    instr_address = 32'hBFC00000;
    tick();
    tick();

    // Halt: active high for 10 RUN edges, then low.
    active = 1'b1;
    repeat (10) tick();
    expect_v("pre_halt_done", 0);   check(32'(done));
    expect_v("pre_halt_cycles", 10); check(cycle_count);
    active = 1'b0;
    tick();
    expect_v("halt_done", 1);       check(32'(done));
    expect_v("halt_fault", 0);      check(32'(fault));
    expect_v("halt_clk_en", 0);     check(32'(clk_enable));
    expect_v("halt_cpu_reset", 0);  check(32'(cpu_reset));
    expect_v("halt_cycles", 11);    check(cycle_count);
    tick();
    expect_v("halt_frozen", 11);    check(cycle_count);

    // Read boundaries, and writes ignored outside RUN.
    data_read = 1'b1; data_address = 32'h1000;
    #1;
    expect_v("rd_oob", 0);          check(data_readdata);
    data_address = 32'h11;
    #1;
    expect_v("rd_misaligned", 0);   check(data_readdata);
    data_read = 1'b0; data_address = 32'h10;
    #1;
    expect_v("rd_disabled", 0);     check(data_readdata);
    instr_address = 32'hBFC00400;
    #1;
    expect_v("imem_oob", 0);        check(instr_readdata);
    instr_address = 32'hBFC00000;
    data_write = 1'b1; data_writedata = 32'h00000001;
    tick();
    data_write = 1'b0; data_read = 1'b1;
    #1;
    expect_v("halt_write_ignored", 32'hDEADBEEF); check(data_readdata);
    data_read = 1'b0;

    // Instruction fetch fault.
    restart(32'h24010020);
    instr_address = 32'h00000004;
    #1;
    expect_v("fetch_oob_rd", 0);    check(instr_readdata);
    tick();
    expect_v("ifault_fault", 1);    check(32'(fault));
    expect_v("ifault_clk_en", 0);   check(32'(clk_enable));
    expect_v("ifault_done", 0);     check(32'(done));
    instr_address = 32'hBFC00000;
    data_write = 1'b1; data_address = 32'h10; data_writedata = 32'h12345678;
    tick();
    data_write = 1'b0; data_read = 1'b1;
    #1;
    expect_v("fault_write_ignored", 32'hDEADBEEF); check(data_readdata);
    data_read = 1'b0;
    expect_v("fault_cycles", 1);    check(cycle_count);

    // Simultaneous read and write faults, winning over a same-cycle halt.
    restart(32'h24010020);
    active = 1'b1;
    tick();
    active = 1'b0; data_read = 1'b1; data_write = 1'b1; data_address = 32'h20;
    data_writedata = 32'h55;
    tick();
    data_read = 1'b0; data_write = 1'b0;
    expect_v("rw_fault", 1);        check(32'(fault));
    expect_v("rw_done", 0);         check(32'(done));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
